// File: rtl/mvau_stream_ctrl.sv
// Sequencer for the MVAU streaming datapath: buffers one input vector and replays it per neuron fold.
// Optional performance counters are built when MVAU_CTRL_PERF_EN is defined.
module mvau_stream_ctrl #(
    parameter int MatrixW = 20,
    parameter int MatrixH = 20,
    parameter int SIMD    = 2,
    parameter int PE      = 2,
    parameter int TSrcI   = 4,
    localparam int SF     = MatrixW / SIMD,
    localparam int NF     = MatrixH / PE,
    localparam int WA_W   = (SF * NF > 1) ? $clog2(SF * NF) : 1,
    localparam int AW     = SIMD * TSrcI
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_v,
    output logic            in_rdy,
    input  logic [AW-1:0]   in_act,
    output logic [AW-1:0]   act_out,
    output logic            act_v,
    output logic [WA_W-1:0] wgt_addr,
    output logic            acc_clr,
    output logic            acc_last,
    output logic            out_v,
    input  logic            out_rdy
`ifdef MVAU_CTRL_PERF_EN
    ,
    output logic [31:0]     perf_vec,
    output logic [31:0]     perf_stall
`endif
);

    localparam int SF_W = (SF > 1) ? $clog2(SF) : 1;
    localparam int NF_W = (NF > 1) ? $clog2(NF) : 1;

    if (MatrixW % SIMD != 0) begin : g_bad_simd
        $fatal(1, "MatrixW must be a multiple of SIMD");
    end
    if (MatrixH % PE != 0) begin : g_bad_pe
        $fatal(1, "MatrixH must be a multiple of PE");
    end

    typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

    state_t            state, state_nxt;
    logic [SF_W-1:0]   sf, sf_nxt;
    logic [NF_W-1:0]   nf, nf_nxt;
    logic              stall;
    logic              sf_last;
    logic              nf_last;
    logic              issue;
    logic              from_buf;
    logic              wr;
    logic              in_rdy_c;
    logic [WA_W-1:0]   addr_cur;

    // Sized to the full index range so the sf counter can address it directly.
    logic [AW-1:0]     ibuf [2**SF_W];

    assign stall    = out_v && !out_rdy;
    assign sf_last  = (sf == SF_W'(SF - 1));
    assign nf_last  = (nf == NF_W'(NF - 1));
    assign addr_cur = WA_W'(int'(nf) * SF + int'(sf));
    assign in_rdy   = in_rdy_c && !rst;
    assign wr       = issue && !from_buf;

    always_comb begin
        state_nxt = state;
        sf_nxt    = sf;
        nf_nxt    = nf;
        in_rdy_c  = 1'b0;
        issue     = 1'b0;
        from_buf  = 1'b0;
        case (state)
            IDLE, WRITE: begin
                in_rdy_c = !stall;
                if (in_v && !stall) begin
                    issue     = 1'b1;
                    state_nxt = WRITE;
                    if (sf_last) begin
                        sf_nxt = '0;
                        if (NF > 1) begin
                            state_nxt = READ;
                            nf_nxt    = NF_W'(1);
                        end
                    end else begin
                        sf_nxt = sf + SF_W'(1);
                    end
                end
            end
            READ: begin
                from_buf = 1'b1;
                if (!stall) begin
                    issue = 1'b1;
                    if (sf_last) begin
                        sf_nxt = '0;
                        if (nf_last) begin
                            state_nxt = WRITE;
                            nf_nxt    = '0;
                        end else begin
                            nf_nxt = nf + NF_W'(1);
                        end
                    end else begin
                        sf_nxt = sf + SF_W'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr) begin
            ibuf[sf] <= in_act;
        end
    end

    // Issue stage: everything the MAC array sees is registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            sf       <= '0;
            nf       <= '0;
            act_v    <= 1'b0;
            acc_clr  <= 1'b0;
            acc_last <= 1'b0;
            out_v    <= 1'b0;
            wgt_addr <= '0;
            act_out  <= '0;
        end else begin
            state    <= state_nxt;
            sf       <= sf_nxt;
            nf       <= nf_nxt;
            act_v    <= issue;
            acc_clr  <= issue && (sf == '0);
            acc_last <= issue && sf_last;
            // A result registered on this edge wins over the handshake clearing the old one.
            out_v    <= (act_v && acc_last) || (out_v && !out_rdy);
            if (issue) begin
                wgt_addr <= addr_cur;
                act_out  <= from_buf ? ibuf[sf] : in_act;
            end
        end
    end

`ifdef MVAU_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_vec   <= '0;
            perf_stall <= '0;
        end else begin
            if (issue && sf_last && nf_last && perf_vec != 32'hFFFF_FFFF) begin
                perf_vec <= perf_vec + 32'd1;
            end
            if (stall && perf_stall != 32'hFFFF_FFFF) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mvau_stream_ctrl.sv
// Bench for mvau_stream_ctrl: SF=4/NF=2 and SF=1/NF=1 instances against a queue-based reference model.
// Perf counters are checked when MVAU_CTRL_PERF_EN is defined.
module tb_mvau_stream_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_v;
    logic [7:0] in_act;
    logic       out_rdy;

    always #5 clk = ~clk;

    logic       in_rdy0, act_v0, clr0, last0, out_v0;
    logic [7:0] act_out0;
    logic [2:0] wgt_addr0;
    logic       in_rdy1, act_v1, clr1, last1, out_v1;
    logic [7:0] act_out1;
    logic [0:0] wgt_addr1;
`ifdef MVAU_CTRL_PERF_EN
    logic [31:0] pvec0, pstall0, pvec1, pstall1, o_pvec, o_pstall;
`endif

    mvau_stream_ctrl #(.MatrixW(8), .MatrixH(4), .SIMD(2), .PE(2), .TSrcI(4)) dut0 (
        .clk(clk), .rst(rst), .in_v(in_v), .in_rdy(in_rdy0), .in_act(in_act),
        .act_out(act_out0), .act_v(act_v0), .wgt_addr(wgt_addr0), .acc_clr(clr0),
        .acc_last(last0), .out_v(out_v0), .out_rdy(out_rdy)
`ifdef MVAU_CTRL_PERF_EN
        , .perf_vec(pvec0), .perf_stall(pstall0)
`endif
    );

    mvau_stream_ctrl #(.MatrixW(2), .MatrixH(2), .SIMD(2), .PE(2), .TSrcI(4)) dut1 (
        .clk(clk), .rst(rst), .in_v(in_v), .in_rdy(in_rdy1), .in_act(in_act),
        .act_out(act_out1), .act_v(act_v1), .wgt_addr(wgt_addr1), .acc_clr(clr1),
        .acc_last(last1), .out_v(out_v1), .out_rdy(out_rdy)
`ifdef MVAU_CTRL_PERF_EN
        , .perf_vec(pvec1), .perf_stall(pstall1)
`endif
    );

    int         sel;
    logic       o_in_rdy, o_act_v, o_clr, o_last, o_out_v;
    logic [7:0] o_act_out;
    logic [2:0] o_addr;

    always_comb begin
        o_in_rdy  = in_rdy0;
        o_act_v   = act_v0;
        o_clr     = clr0;
        o_last    = last0;
        o_out_v   = out_v0;
        o_act_out = act_out0;
        o_addr    = wgt_addr0;
`ifdef MVAU_CTRL_PERF_EN
        o_pvec    = pvec0;
        o_pstall  = pstall0;
`endif
        if (sel == 1) begin
            o_in_rdy  = in_rdy1;
            o_act_v   = act_v1;
            o_clr     = clr1;
            o_last    = last1;
            o_out_v   = out_v1;
            o_act_out = act_out1;
            o_addr    = {2'b00, wgt_addr1};
`ifdef MVAU_CTRL_PERF_EN
            o_pvec    = pvec1;
            o_pstall  = pstall1;
`endif
        end
    end

    int tests = 0;
    int fails = 0;

    // Reference model: words awaiting replay, the vector being collected, and expected outputs.
    int         msf, mnf;
    logic [7:0] rq[$];
    logic [7:0] vq[$];
    logic       m_av, m_clr, m_last, m_ov;
    logic [7:0] m_aout;
    int         m_addr, cnt, m_vec, m_stall;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic iv, input logic [7:0] ia, input logic ordy, output logic acc);
        logic       stl;
        logic       iss;
        logic [7:0] w;
        @(negedge clk);
        in_v    = iv;
        in_act  = ia;
        out_rdy = ordy;
        #1;
        acc = 1'b0;
        w   = 8'h00;
        if (rst) begin
            chk("in_rdy_rst", {31'd0, o_in_rdy}, 32'd0);
            rq.delete();
            vq.delete();
            m_av = 0; m_clr = 0; m_last = 0; m_ov = 0; m_aout = 8'h00;
            m_addr = 0; cnt = 0; m_vec = 0; m_stall = 0;
        end else begin
            stl = m_ov && !ordy;
            chk("in_rdy", {31'd0, o_in_rdy}, {31'd0, !stl && rq.size() == 0});
            if (stl) m_stall++;
            iss = 1'b0;
            if (!stl && rq.size() > 0) begin
                w   = rq.pop_front();
                iss = 1'b1;
            end else if (!stl && iv) begin
                w   = ia;
                iss = 1'b1;
                acc = 1'b1;
                vq.push_back(ia);
                if (vq.size() == msf) begin
                    for (int k = 1; k < mnf; k++)
                        foreach (vq[j]) rq.push_back(vq[j]);
                    vq.delete();
                end
            end
            m_ov = (m_av && m_last) || (m_ov && !ordy);
            m_av = iss;
            if (iss) begin
                m_aout = w;
                m_addr = cnt;
                m_clr  = (cnt % msf == 0);
                m_last = (cnt % msf == msf - 1);
                if (cnt == msf * mnf - 1) m_vec++;
                cnt = (cnt + 1) % (msf * mnf);
            end else begin
                m_clr  = 1'b0;
                m_last = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        chk("act_v",    {31'd0, o_act_v},  {31'd0, m_av});
        chk("act_out",  {24'd0, o_act_out}, {24'd0, m_aout});
        chk("wgt_addr", {29'd0, o_addr},   m_addr);
        chk("acc_clr",  {31'd0, o_clr},    {31'd0, m_clr});
        chk("acc_last", {31'd0, o_last},   {31'd0, m_last});
        chk("out_v",    {31'd0, o_out_v},  {31'd0, m_ov});
    endtask

    initial begin
        logic       a;
        logic [7:0] d;
        int         guard;
        sel = 0; msf = 4; mnf = 2;
        rst = 1'b1; in_v = 1'b0; in_act = 8'h00; out_rdy = 1'b1;
        step(0, 8'h00, 1, a);
        step(0, 8'h00, 1, a);
        rst = 1'b0;

        // Single vector, full throughput
        step(1, 8'h11, 1, a);
        step(1, 8'h22, 1, a);
        step(1, 8'h33, 1, a);
        step(1, 8'h44, 1, a);
        repeat (6) step(0, 8'h00, 1, a);

        // Back-to-back vectors with in_v held high
        d = 8'($urandom);
        repeat (20) begin
            step(1, d, 1, a);
            if (a) d = 8'($urandom);
        end
        repeat (10) step(0, 8'h00, 1, a);

        // Downstream stall on the first result
        guard = 0;
        d = 8'h11;
        while (!m_ov && guard < 40) begin
            step(1, d, 1, a);
            if (a) d = d + 8'h11;
            guard++;
        end
        chk("stall_reach", {31'd0, m_ov}, 32'd1);
        repeat (5) step(1, d, 0, a);
        repeat (14) begin
            step(1, d, 1, a);
            if (a) d = d + 8'h11;
        end

        // in_v toggling while collecting
        for (int i = 0; i < 24; i++) begin
            step(i[0] == 1'b0, 8'($urandom), 1, a);
        end
        repeat (10) step(0, 8'h00, 1, a);

        // Reset in the middle of a vector
        step(1, 8'hA1, 1, a);
        step(1, 8'hA2, 1, a);
        rst = 1'b1;
        step(0, 8'h00, 1, a);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) step(1, 8'(8'hB0 + i), 1, a);

        // Random traffic
        repeat (300) step($urandom_range(0, 1) == 1, 8'($urandom), $urandom_range(0, 3) != 0, a);
`ifdef MVAU_CTRL_PERF_EN
        chk("perf_vec0", o_pvec, m_vec);
        chk("perf_stall0", o_pstall, m_stall);
`endif

        // SF=1, NF=1 instance
        sel = 1; msf = 1; mnf = 1;
        rst = 1'b1;
        step(0, 8'h00, 1, a);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) step(1, 8'($urandom), 1, a);
`ifdef MVAU_CTRL_PERF_EN
        chk("perf_vec10", o_pvec, 32'd10);
        chk("perf_stall10", o_pstall, 32'd0);
`endif
        repeat (150) step($urandom_range(0, 1) == 1, 8'($urandom), $urandom_range(0, 2) != 0, a);
`ifdef MVAU_CTRL_PERF_EN
        chk("perf_vec1", o_pvec, m_vec);
        chk("perf_stall1", o_pstall, m_stall);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
